// File: rtl/tdi_capture_writer_pkg.sv
// Shared definitions for the TDI capture path: TAP state codes, capture address
// width and the write-cycle FSM encoding.
package tdi_capture_writer_pkg;

    localparam int ADR_W = 21;

    typedef enum logic [3:0] {
        TAP_TLR   = 4'd0,
        TAP_RTI   = 4'd1,
        TAP_SELDR = 4'd2,
        TAP_CAPDR = 4'd3,
        TAP_SELIR = 4'd4,
        TAP_CAPIR = 4'd5,
        TAP_SHDR  = 4'd6,
        TAP_SHIR  = 4'd7,
        TAP_EX1DR = 4'd8,
        TAP_EX1IR = 4'd9,
        TAP_PADR  = 4'd10,
        TAP_PAIR  = 4'd11,
        TAP_EX2DR = 4'd12,
        TAP_EX2IR = 4'd13,
        TAP_UPDR  = 4'd14,
        TAP_UPIR  = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_SETUP,
        CYC_STROBE,
        CYC_HOLD
    } wr_cycle_t;

    function automatic logic is_shift(input logic [3:0] s);
        return (s == TAP_SHDR) || (s == TAP_SHIR);
    endfunction

    function automatic logic is_exit1(input logic [3:0] s);
        return (s == TAP_EX1DR) || (s == TAP_EX1IR);
    endfunction

endpackage

// File: rtl/tdi_capture_writer_wr_cycle.sv
// RAM write-cycle timer: SETUP -> STROBE (wr_n low) -> HOLD, each phase a fixed
// number of clk cycles. 'last' marks the final HOLD cycle so the owner can step the address.
module tdi_wr_cycle
    import tdi_capture_writer_pkg::*;
#(
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic idle,
    output logic last,
    output logic wr_n
);

    localparam int CNT_W = 16;

    wr_cycle_t        st_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign idle = (st_reg == CYC_IDLE);
    assign last = (st_reg == CYC_HOLD) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg  <= CYC_IDLE;
            cnt_reg <= '0;
            wr_n    <= 1'b1;
        end else begin
            case (st_reg)
                CYC_IDLE: begin
                    if (start) begin
                        st_reg  <= CYC_SETUP;
                        cnt_reg <= CNT_W'(WR_SETUP - 1);
                    end
                end
                CYC_SETUP: begin
                    if (cnt_reg == '0) begin
                        st_reg  <= CYC_STROBE;
                        cnt_reg <= CNT_W'(WR_PULSE - 1);
                        wr_n    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                CYC_STROBE: begin
                    if (cnt_reg == '0) begin
                        st_reg  <= CYC_HOLD;
                        cnt_reg <= CNT_W'(WR_HOLD - 1);
                        wr_n    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                CYC_HOLD: begin
                    if (cnt_reg == '0) begin
                        st_reg <= CYC_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: st_reg <= CYC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tdi_capture_writer.sv
// Samples TDI during SHIFT-DR/IR, packs bits LSB-first into bytes and writes each
// byte to the capture RAM through a one-entry holding register.
module tdi_capture_writer
    import tdi_capture_writer_pkg::*;
#(
    parameter int               WR_SETUP = 1,
    parameter int               WR_PULSE = 2,
    parameter int               WR_HOLD  = 1,
    parameter logic [ADR_W-1:0] ADR_LAST = 21'h1FFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       state,
    input  logic             tck_smp,
    input  logic             tdi,
    input  logic             cap_en,
    input  logic             adr_ld,
    input  logic [ADR_W-1:0] adr_start,
    output logic [ADR_W-1:0] a_ram,
    output logic [7:0]       d_ram,
    output logic             d_ram_oe,
    output logic             wr_ram_n,
    output logic             busy,
    output logic             overrun,
    output logic             overflow
);

    logic [3:0]       state_prev_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       sreg_reg;
    logic [7:0]       hold_reg;
    logic             hold_full_reg;
    logic [7:0]       d_ram_reg;
    logic             oe_reg;
    logic             overrun_reg;
    logic             overflow_reg;
    logic [ADR_W:0]   adr_cnt_reg;
    logic             adr_pend_reg;
    logic [ADR_W-1:0] adr_pend_val_reg;

    logic       sample, byte_done, flush, new_byte;
    logic       hold_free, take, start, adr_over;
    logic       cyc_idle, cyc_last;
    logic [7:0] sreg_with_bit, byte_next;

    assign sample        = tck_smp && cap_en && is_shift(state);
    assign byte_done     = sample && (bit_cnt_reg == 3'd7);
    assign flush         = cap_en && is_exit1(state) && (state != state_prev_reg)
                           && (bit_cnt_reg != 3'd0);
    assign new_byte      = byte_done || flush;
    // Bits above bit_cnt are always zero, so OR-ing in the new bit is enough.
    assign sreg_with_bit = sreg_reg | (8'(tdi) << bit_cnt_reg);
    assign byte_next     = sample ? sreg_with_bit : sreg_reg;

    // Counter is one bit wider than the bus so ADR_LAST+1 is representable without wrapping.
    assign adr_over  = adr_cnt_reg > {1'b0, ADR_LAST};
    assign take      = cyc_idle && hold_full_reg;
    assign start     = take && !adr_over;
    assign hold_free = !hold_full_reg || take;

    tdi_wr_cycle #(
        .WR_SETUP (WR_SETUP),
        .WR_PULSE (WR_PULSE),
        .WR_HOLD  (WR_HOLD)
    ) u_wr_cycle (
        .clk   (clk),
        .rst_n (reset_n),
        .start (start),
        .idle  (cyc_idle),
        .last  (cyc_last),
        .wr_n  (wr_ram_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_prev_reg   <= 4'd0;
            bit_cnt_reg      <= 3'd0;
            sreg_reg         <= 8'h00;
            hold_reg         <= 8'h00;
            hold_full_reg    <= 1'b0;
            d_ram_reg        <= 8'h00;
            oe_reg           <= 1'b0;
            overrun_reg      <= 1'b0;
            overflow_reg     <= 1'b0;
            adr_cnt_reg      <= '0;
            adr_pend_reg     <= 1'b0;
            adr_pend_val_reg <= '0;
        end else begin
            state_prev_reg <= state;

            if (state == TAP_TLR) begin
                bit_cnt_reg <= 3'd0;
                sreg_reg    <= 8'h00;
            end else if (sample) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                sreg_reg    <= byte_done ? 8'h00 : sreg_with_bit;
            end else if (flush) begin
                bit_cnt_reg <= 3'd0;
                sreg_reg    <= 8'h00;
            end

            if (new_byte && hold_free) begin
                hold_reg      <= byte_next;
                hold_full_reg <= 1'b1;
            end else if (take) begin
                hold_full_reg <= 1'b0;
            end

            // Clearing by adr_ld comes first so a same-edge event still sets the flag.
            if (adr_ld) begin
                overrun_reg  <= 1'b0;
                overflow_reg <= 1'b0;
            end
            if (new_byte && !hold_free) overrun_reg <= 1'b1;
            if (take && adr_over)       overflow_reg <= 1'b1;

            if (start) begin
                d_ram_reg <= hold_reg;
                oe_reg    <= 1'b1;
            end else if (cyc_last) begin
                oe_reg <= 1'b0;
            end

            // A load arriving mid-cycle is parked and applied once the cycle is over.
            if (adr_ld && (!cyc_idle || start)) begin
                adr_pend_reg     <= 1'b1;
                adr_pend_val_reg <= adr_start;
            end
            if (cyc_idle && !start && (adr_ld || adr_pend_reg)) begin
                adr_cnt_reg  <= {1'b0, (adr_ld ? adr_start : adr_pend_val_reg)};
                adr_pend_reg <= 1'b0;
            end else if (cyc_last && !adr_over) begin
                adr_cnt_reg <= adr_cnt_reg + 1'b1;
            end
        end
    end

    assign a_ram    = adr_cnt_reg[ADR_W-1:0];
    assign d_ram    = d_ram_reg;
    assign d_ram_oe = oe_reg;
    assign busy     = !cyc_idle || hold_full_reg;
    assign overrun  = overrun_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_tdi_capture_writer.sv
// Two instances (nominal strobe and a long strobe that stalls the writer) share one
// stimulus stream; each is checked against a byte/write-slot reference model.
module tb_tdi_capture_writer;

    localparam int          PULSE_A  = 2;
    localparam int          PULSE_B  = 40;
    localparam logic [20:0] ADR_LAST = 21'h1FFFFF;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  state;
    logic        tck_smp, tdi, cap_en, adr_ld;
    logic [20:0] adr_start;

    logic [20:0] a_ram_w [2];
    logic [7:0]  d_ram_w [2];
    logic        oe_w [2];
    logic        wr_w [2];
    logic        busy_w [2];
    logic        ovr_w [2];
    logic        ovf_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdi_capture_writer #(.WR_SETUP(1), .WR_PULSE(PULSE_A), .WR_HOLD(1), .ADR_LAST(ADR_LAST)) dut_a (
        .clk(clk), .reset_n(reset_n), .state(state), .tck_smp(tck_smp), .tdi(tdi),
        .cap_en(cap_en), .adr_ld(adr_ld), .adr_start(adr_start),
        .a_ram(a_ram_w[0]), .d_ram(d_ram_w[0]), .d_ram_oe(oe_w[0]), .wr_ram_n(wr_w[0]),
        .busy(busy_w[0]), .overrun(ovr_w[0]), .overflow(ovf_w[0]));

    tdi_capture_writer #(.WR_SETUP(1), .WR_PULSE(PULSE_B), .WR_HOLD(1), .ADR_LAST(ADR_LAST)) dut_b (
        .clk(clk), .reset_n(reset_n), .state(state), .tck_smp(tck_smp), .tdi(tdi),
        .cap_en(cap_en), .adr_ld(adr_ld), .adr_start(adr_start),
        .a_ram(a_ram_w[1]), .d_ram(d_ram_w[1]), .d_ram_oe(oe_w[1]), .wr_ram_n(wr_w[1]),
        .busy(busy_w[1]), .overrun(ovr_w[1]), .overflow(ovf_w[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         pk_n;
    logic [7:0] pk_b;
    logic [3:0] prev_st;
    logic       nb;
    logic [7:0] nb_d;
    int         nb_cyc;
    int         m_addr [2];
    logic       m_hold_v [2];
    logic [7:0] m_hold_d [2];
    int         m_next [2];
    int         m_busy_until [2];
    logic       m_ovr [2];
    logic       m_ovf [2];
    wr_t        exp_q0 [$];
    wr_t        exp_q1 [$];

    function automatic int cycle_len(input int m);
        return 1 + ((m == 0) ? PULSE_A : PULSE_B) + 1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            pk_n = 0; pk_b = 8'h00; prev_st = 4'd0;
            for (int m = 0; m < 2; m++) begin
                m_addr[m] = 0; m_hold_v[m] = 1'b0; m_hold_d[m] = 8'h00;
                m_next[m] = 0; m_busy_until[m] = 0; m_ovr[m] = 1'b0; m_ovf[m] = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            nb = 1'b0; nb_d = 8'h00;
            if (state == 4'd0) begin
                pk_n = 0; pk_b = 8'h00;
            end else if (tck_smp && cap_en && (state == 4'd6 || state == 4'd7)) begin
                pk_b[pk_n] = tdi;
                pk_n++;
                if (pk_n == 8) begin
                    nb = 1'b1; nb_d = pk_b; pk_n = 0; pk_b = 8'h00;
                end
            end else if (cap_en && (state == 4'd8 || state == 4'd9) && state != prev_st && pk_n != 0) begin
                nb = 1'b1; nb_d = pk_b; pk_n = 0; pk_b = 8'h00;
            end
            prev_st = state;
            if (nb) nb_cyc = cyc;
            for (int m = 0; m < 2; m++) begin
                if (adr_ld) begin
                    m_addr[m] = int'(adr_start); m_ovr[m] = 1'b0; m_ovf[m] = 1'b0;
                end
                if (m_hold_v[m] && cyc >= m_next[m]) begin
                    m_hold_v[m] = 1'b0;
                    if (m_addr[m] > int'(ADR_LAST)) begin
                        m_ovf[m]  = 1'b1;
                        m_next[m] = cyc + 1;
                    end else begin
                        wr_t w;
                        w.addr = m_addr[m]; w.data = m_hold_d[m];
                        if (m == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
                        m_addr[m]++;
                        m_busy_until[m] = cyc + cycle_len(m);
                        m_next[m]       = cyc + cycle_len(m) + 1;
                    end
                end
                if (nb) begin
                    if (m_hold_v[m]) m_ovr[m] = 1'b1;
                    else begin m_hold_v[m] = 1'b1; m_hold_d[m] = nb_d; end
                end
            end
        end
    end

    // ---------------- write monitor ----------------
    logic        prev_wr [2] = '{1'b1, 1'b1};
    int          low_cnt [2] = '{0, 0};
    int          fall_cyc [2];
    int          nwrites [2] = '{0, 0};
    logic [20:0] last_a [2];
    logic [7:0]  last_d [2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                prev_wr[m] = 1'b1; low_cnt[m] = 0;
            end else begin
                if (!wr_w[m]) begin
                    if (prev_wr[m]) begin
                        logic have;
                        wr_t  w;
                        fall_cyc[m] = cyc; last_a[m] = a_ram_w[m]; last_d[m] = d_ram_w[m];
                        nwrites[m]++;
                        low_cnt[m] = 0;
                        have = (m == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                        chk($sformatf("wr_expected_%0d", m), {31'b0, have}, 32'd1);
                        if (have) begin
                            if (m == 0) w = exp_q0.pop_front(); else w = exp_q1.pop_front();
                            chk($sformatf("wr_addr_%0d", m), {11'b0, a_ram_w[m]}, w.addr);
                            chk($sformatf("wr_data_%0d", m), {24'b0, d_ram_w[m]}, {24'b0, w.data});
                            chk($sformatf("wr_oe_%0d", m), {31'b0, oe_w[m]}, 32'd1);
                        end
                    end
                    low_cnt[m]++;
                end else if (!prev_wr[m]) begin
                    chk($sformatf("strobe_width_%0d", m), low_cnt[m], (m == 0) ? PULSE_A : PULSE_B);
                end
                prev_wr[m] = wr_w[m];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic smp(input logic b, input int gap);
        @(negedge clk);
        tdi = b; tck_smp = 1'b1;
        @(negedge clk);
        tck_smp = 1'b0;
        for (int m = 0; m < 2; m++)
            chk($sformatf("busy_%0d", m), {31'b0, busy_w[m]},
                {31'b0, (m_hold_v[m] || cyc < m_busy_until[m])});
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic set_state(input logic [3:0] s);
        @(negedge clk);
        state = s;
        @(negedge clk);
    endtask

    task automatic load_adr(input logic [20:0] a);
        @(negedge clk);
        adr_start = a; adr_ld = 1'b1;
        @(negedge clk);
        adr_ld = 1'b0;
    endtask

    task automatic exit_dr();
        set_state(4'd8); set_state(4'd14); set_state(4'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_w[0] || busy_w[1] || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_in_time", {31'b0, (n < 3000)}, 32'd1);
        chk("pending_writes", exp_q0.size() + exp_q1.size(), 0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("idle_busy_%0d", m), {31'b0, busy_w[m]},
                {31'b0, (m_hold_v[m] || cyc < m_busy_until[m])});
            chk($sformatf("overrun_%0d", m), {31'b0, ovr_w[m]}, {31'b0, m_ovr[m]});
            chk($sformatf("overflow_%0d", m), {31'b0, ovf_w[m]}, {31'b0, m_ovf[m]});
            chk($sformatf("idle_oe_%0d", m), {31'b0, oe_w[m]}, 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] t1_bits;
        int         w0, w1;
        reset_n = 1'b0; state = 4'd0; tck_smp = 1'b0; tdi = 1'b0;
        cap_en = 1'b0; adr_ld = 1'b0; adr_start = '0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_a_%0d", m), {11'b0, a_ram_w[m]}, 0);
            chk($sformatf("rst_d_%0d", m), {24'b0, d_ram_w[m]}, 0);
            chk($sformatf("rst_oe_%0d", m), {31'b0, oe_w[m]}, 0);
            chk($sformatf("rst_wr_%0d", m), {31'b0, wr_w[m]}, 1);
            chk($sformatf("rst_busy_%0d", m), {31'b0, busy_w[m]}, 0);
            chk($sformatf("rst_ovr_%0d", m), {31'b0, ovr_w[m]}, 0);
            chk($sformatf("rst_ovf_%0d", m), {31'b0, ovf_w[m]}, 0);
        end
        @(negedge clk);
        reset_n = 1'b1; cap_en = 1'b1;

        // One byte, LSB first: 1,0,1,1,0,0,1,0 -> 8'h4D at 0x100
        load_adr(21'h00100);
        set_state(4'd6);
        t1_bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) smp(t1_bits[i], 2);
        wait_idle();
        chk("t1_addr", {11'b0, last_a[0]}, 32'h100);
        chk("t1_data", {24'b0, last_d[0]}, 32'h4D);
        chk("t1_latency", fall_cyc[0] - nb_cyc, 2);
        chk("t1_latency_b", fall_cyc[1] - nb_cyc, 2);

        // Partial IR byte flushed on EXIT1-IR, then a full byte proves bit_cnt restarted
        set_state(4'd7);
        for (int i = 0; i < 3; i++) smp(1'b1, 2);
        set_state(4'd9); set_state(4'd15); set_state(4'd1);
        wait_idle();
        chk("t2_addr", {11'b0, last_a[0]}, 32'h101);
        chk("t2_data", {24'b0, last_d[0]}, 32'h07);
        set_state(4'd6);
        for (int i = 0; i < 8; i++) smp(1'($urandom_range(0, 1)), 2);
        exit_dr();
        wait_idle();
        chk("t2_next_addr", {11'b0, last_a[0]}, 32'h102);

        // 24 bits at the minimum sample spacing; the long-strobe instance must overrun
        load_adr(21'h00200);
        w0 = nwrites[0]; w1 = nwrites[1];
        set_state(4'd6);
        for (int i = 0; i < 24; i++) smp(1'($urandom_range(0, 1)), 2);
        exit_dr();
        wait_idle();
        chk("t3_writes_a", nwrites[0] - w0, 3);
        chk("t3_writes_b", nwrites[1] - w1, 2);
        chk("t3_ovr_a", {31'b0, ovr_w[0]}, 0);
        chk("t3_ovr_b", {31'b0, ovr_w[1]}, 1);

        // Randomised bursts with random spacing, flushes and TLR aborts
        load_adr(21'h01000);
        for (int it = 0; it < 8; it++) begin
            int nbits, gap;
            nbits = int'($urandom_range(1, 20));
            gap   = int'($urandom_range(2, 5));
            set_state(($urandom_range(0, 1) == 0) ? 4'd6 : 4'd7);
            for (int i = 0; i < nbits; i++) smp(1'($urandom_range(0, 1)), gap);
            if ($urandom_range(0, 3) == 0) set_state(4'd0);
            else set_state(($urandom_range(0, 1) == 0) ? 4'd8 : 4'd9);
            set_state(4'd1);
        end
        wait_idle();

        // Last writable address: one write, second byte discarded
        load_adr(ADR_LAST);
        w0 = nwrites[0];
        set_state(4'd6);
        for (int i = 0; i < 16; i++) smp(1'($urandom_range(0, 1)), 2);
        exit_dr();
        wait_idle();
        chk("t5_writes_a", nwrites[0] - w0, 1);
        chk("t5_addr", {11'b0, last_a[0]}, {11'b0, ADR_LAST});
        chk("t5_ovf_a", {31'b0, ovf_w[0]}, 1);
        chk("t5_ovf_b", {31'b0, ovf_w[1]}, 1);

        // cap_en low: sampling and flush suppressed; TLR discards the partial byte
        load_adr(21'h00300);
        w0 = nwrites[0];
        set_state(4'd6);
        for (int i = 0; i < 3; i++) smp(1'($urandom_range(0, 1)), 2);
        @(negedge clk) cap_en = 1'b0;
        for (int i = 0; i < 8; i++) smp(1'($urandom_range(0, 1)), 2);
        set_state(4'd8); set_state(4'd0);
        @(negedge clk) cap_en = 1'b1;
        set_state(4'd1); set_state(4'd6);
        for (int i = 0; i < 8; i++) smp(1'($urandom_range(0, 1)), 3);
        exit_dr();
        wait_idle();
        chk("t6_writes_a", nwrites[0] - w0, 1);
        chk("t6_addr", {11'b0, last_a[0]}, 32'h300);

        // Asynchronous reset in the middle of a strobe
        load_adr(21'h00040);
        set_state(4'd6);
        for (int i = 0; i < 8; i++) smp(1'($urandom_range(0, 1)), 2);
        begin
            int n = 0;
            while (wr_w[0] && n < 50) begin @(negedge clk); n++; end
        end
        chk("t7_in_strobe", {31'b0, wr_w[0]}, 0);
        #2 reset_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t7_wr_%0d", m), {31'b0, wr_w[m]}, 1);
            chk($sformatf("t7_oe_%0d", m), {31'b0, oe_w[m]}, 0);
            chk($sformatf("t7_busy_%0d", m), {31'b0, busy_w[m]}, 0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load_adr(21'h00050);
        for (int i = 0; i < 8; i++) smp(1'($urandom_range(0, 1)), 2);
        exit_dr();
        wait_idle();
        chk("t7_recover_addr", {11'b0, last_a[0]}, 32'h50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
